// File: rtl/input_conditioner.sv
// Per-channel conditioning of asynchronous board inputs: 2-flop synchroniser, debounce,
// edge pulses, optional auto-repeat press and a press-toggled latch.
module input_conditioner #(
  parameter int                  CHANNELS        = 8,
  parameter int                  DEBOUNCE_CYCLES = 650000,
  parameter int                  CNT_WIDTH       = 20,
  parameter logic [CHANNELS-1:0] REPEAT_MASK     = '0,
  parameter int                  REPEAT_DELAY    = 32500000,
  parameter int                  REPEAT_PERIOD   = 6500000,
  parameter int                  RPT_WIDTH       = 26
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] toggle
);

  localparam logic [CNT_WIDTH-1:0] DB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_WIDTH-1:0] DELAY_TGT  = RPT_WIDTH'(REPEAT_DELAY);
  localparam logic [RPT_WIDTH-1:0] PERIOD_TGT = RPT_WIDTH'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_FIRST,
    RPT_PERIODIC
  } rpt_state_t;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] clean_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      clean_d <= '0;
      toggle  <= '0;
    end else begin
      sync1   <= noisy;
      sync2   <= sync1;
      clean_d <= clean;
      toggle  <= toggle ^ rise;
    end
  end

  assign rise = clean & ~clean_d;
  assign fall = ~clean & clean_d;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [CNT_WIDTH-1:0] cnt;
    logic                 clean_q;

    // Any sample equal to the current level discards the run in progress.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt     <= '0;
        clean_q <= 1'b0;
      end else if (sync2[ch] == clean_q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        clean_q <= sync2[ch];
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign clean[ch] = clean_q;

    if (REPEAT_MASK[ch]) begin : g_repeat
      rpt_state_t           state_q, state_d;
      logic [RPT_WIDTH-1:0] rcnt_q, rcnt_d;
      logic                 fire;

      always_ff @(posedge clock) begin
        if (reset) begin
          state_q <= RPT_IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end

      // rcnt_q holds the number of cycles elapsed since the rise or the last repeat.
      // NOTE: every output of this block gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        fire    = 1'b0;
        if (!clean_q) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            RPT_IDLE: begin
              state_d = RPT_FIRST;
              rcnt_d  = RPT_WIDTH'(1);
            end
            RPT_FIRST: begin
              if (rcnt_q == DELAY_TGT) begin
                fire    = 1'b1;
                state_d = RPT_PERIODIC;
                rcnt_d  = RPT_WIDTH'(1);
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            RPT_PERIODIC: begin
              if (rcnt_q == PERIOD_TGT) begin
                fire   = 1'b1;
                rcnt_d = RPT_WIDTH'(1);
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            default: begin
              state_d = RPT_IDLE;
              rcnt_d  = '0;
            end
          endcase
        end
      end

      assign press[ch] = rise[ch] | fire;
    end else begin : g_no_repeat
      assign press[ch] = rise[ch];
    end
  end

endmodule
